// File: rtl/muldiv_hilo_unit.sv
// Iterative MIPS multiply/divide unit with the architectural HI/LO pair.
// One shift-add or restoring shift-subtract step per cycle, then a sign fix-up cycle.
module muldiv_hilo_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic             rd_sel_hi,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e                 state_q;
    logic [1:0]             op_q;
    logic [WIDTH-1:0]       a_q;
    logic [WIDTH-1:0]       b_q;
    logic [WIDTH-1:0]       raw_a_q;
    logic                   neg_a_q;
    logic                   neg_b_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [2*WIDTH-1:0]     acc_q;
    logic [WIDTH-1:0]       hi_q;
    logic [WIDTH-1:0]       lo_q;
    logic                   done_q;

    // Operand magnitudes at launch; op[0]=0 marks the signed variants.
    logic                   a_neg_d;
    logic                   b_neg_d;
    logic [WIDTH-1:0]       a_mag_d;
    logic [WIDTH-1:0]       b_mag_d;

    always_comb begin
        a_neg_d = ~op[0] & rs_data[WIDTH-1];
        b_neg_d = ~op[0] & rt_data[WIDTH-1];
        a_mag_d = a_neg_d ? (~rs_data + 1'b1) : rs_data;
        b_mag_d = b_neg_d ? (~rt_data + 1'b1) : rt_data;
    end

    // Multiply step: add multiplicand into the upper half when the low bit is set, then shift right.
    logic [WIDTH:0]         mul_sum;
    logic [2*WIDTH-1:0]     mul_next;
    // Divide step: shift the remainder left, subtract the divisor if it fits.
    logic [WIDTH:0]         div_rem;
    logic                   div_ge;
    logic [WIDTH-1:0]       div_sub;
    logic [2*WIDTH-1:0]     div_next;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                   (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
        div_rem  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge   = (div_rem >= {1'b0, b_q});
        div_sub  = div_rem[WIDTH-1:0] - b_q;
        div_next = {(div_ge ? div_sub : div_rem[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
    end

    // Fix-up: restore signs and handle divide by zero.
    logic                   sign_diff;
    logic [2*WIDTH-1:0]     prod_fix;
    logic [WIDTH-1:0]       quot_fix;
    logic [WIDTH-1:0]       rem_fix;
    logic [WIDTH-1:0]       hi_res;
    logic [WIDTH-1:0]       lo_res;

    always_comb begin
        sign_diff = neg_a_q ^ neg_b_q;
        prod_fix  = sign_diff ? (~acc_q + 1'b1) : acc_q;
        quot_fix  = sign_diff ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
        rem_fix   = neg_a_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
        if (!op_q[1]) begin
            hi_res = prod_fix[2*WIDTH-1:WIDTH];
            lo_res = prod_fix[WIDTH-1:0];
        end else if (b_q == '0) begin
            hi_res = raw_a_q;
            lo_res = '1;
        end else begin
            hi_res = rem_fix;
            lo_res = quot_fix;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= 2'b00;
            a_q     <= '0;
            b_q     <= '0;
            raw_a_q <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        raw_a_q <= rs_data;
                        a_q     <= a_mag_d;
                        b_q     <= b_mag_d;
                        neg_a_q <= a_neg_d;
                        neg_b_q <= b_neg_d;
                        cnt_q   <= '0;
                        acc_q   <= {{WIDTH{1'b0}}, (op[1] ? a_mag_d : b_mag_d)};
                        state_q <= S_CALC;
                    end else begin
                        if (mthi) hi_q <= rs_data;
                        if (mtlo) lo_q <= rs_data;
                    end
                end
                S_CALC: begin
                    acc_q <= op_q[1] ? div_next : mul_next;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH-1)) state_q <= S_FIX;
                end
                S_FIX: begin
                    hi_q    <= hi_res;
                    lo_q    <= lo_res;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign hi      = hi_q;
    assign lo      = lo_q;
    assign done    = done_q;
    assign busy    = (state_q != S_IDLE);
    assign rd_data = rd_sel_hi ? hi_q : lo_q;

endmodule
